fu_issue_queue: RTL and testbench
=================================

FU_ISSUE_QUEUE -- requirements
Module: fu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  core clock; single clock domain.
REQ-003 rstn  input  1  reset; asynchronous assert, active-low.
REQ-004 dispatch_i  input  fu_input_t  instruction from dispatch; carries fu and id fields.
REQ-005 dispatch_i_valid  input  1  dispatch_i holds a valid instruction.
REQ-006 dispatch_i_ready  output  1  queue accepts dispatch_i this cycle.
REQ-007 flush_i  input  1  discard all queued instructions.
REQ-008 fuinput_o  output  fu_input_t  head instruction to functional units.
REQ-009 fuinput_o_valid  output  1  fuinput_o is valid.
REQ-010 fuinput_o_ready  input  fu_bitvector_t  per-FU ready, indexed by fu_t.
REQ-011 count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-012 Queue SHALL be a circular FIFO with read pointer, write pointer and occupancy counter; both pointers wrap from DEPTH-1 to 0.
REQ-013 Enqueue SHALL occur on a rising clk edge when dispatch_i_valid && dispatch_i_ready.
REQ-014 dispatch_i_ready SHALL equal (count_o < DEPTH) and SHALL NOT depend combinationally on fuinput_o_ready or on any input other than flush_i.
REQ-015 dispatch_i_ready SHALL be 0 while flush_i is 1.
REQ-016 Issue SHALL occur when fuinput_o_valid && fuinput_o_ready[fuinput_o.fu].
REQ-017 Issue SHALL be strictly in program order; only the head entry is ever presented.
REQ-018 fuinput_o_valid SHALL NOT depend combinationally on fuinput_o_ready.
REQ-019 While fuinput_o_valid is 1 and no issue occurs, fuinput_o SHALL remain stable on the next cycle unless flush_i is 1.
REQ-020 fuinput_o SHALL be all-zero whenever fuinput_o_valid is 0.
REQ-021 Head instruction whose FU ready bit stays 0 SHALL block the queue indefinitely; no instruction SHALL be dropped.
REQ-022 Simultaneous enqueue and issue SHALL leave count_o unchanged and advance both pointers.
REQ-023 count_o SHALL increment on enqueue-only, decrement on issue-only and never exceed DEPTH or go below 0.
REQ-024 flush_i SHALL, on the next edge, set count_o to 0 and both pointers to 0; enqueue and issue in the flush cycle SHALL be suppressed.
REQ-025 fuinput_o_valid SHALL be 0 in the flush cycle.
REQ-026 Without bypass, minimum enqueue-to-fuinput_o_valid latency SHALL be 1 cycle.

Reset
REQ-027 On rstn low, all pointers, count_o, fuinput_o_valid and fuinput_o SHALL be 0 asynchronously; dispatch_i_ready SHALL be 1 one cycle after rstn deasserts.
REQ-028 Reset mid-operation SHALL discard all entries without issuing them.
REQ-029 Storage array contents need no reset.

Configuration
REQ-030 Macro FU_ISSUE_QUEUE_BYPASS_EN: when defined, with count_o == 0, no flush and dispatch_i_valid, fuinput_o SHALL equal dispatch_i and fuinput_o_valid SHALL be 1 in the same cycle; if the FU accepts, the entry SHALL NOT be written and count_o stays 0; otherwise it is enqueued normally.
REQ-031 When FU_ISSUE_QUEUE_BYPASS_EN is undefined, no combinational path SHALL exist from dispatch_i to fuinput_o; REQ-026 applies.

Verification
REQ-032 Reset, then enqueue ids 1..4 with all FU ready low -> count_o=4, dispatch_i_ready=0, fuinput_o.id=1 held stable for 10 cycles.
REQ-033 Queue full, raise ready for head FU only -> ids 1,2,3,4 issue in order one per cycle; dispatch_i_ready returns to 1 after the first issue.
REQ-034 Head id=5 targets FU_LSU, id=6 targets FU_ALU; only FU_ALU ready -> nothing issues and count_o=2 unchanged.
REQ-035 count_o=3, flush_i pulsed with dispatch_i_valid=1 -> next cycle count_o=0, fuinput_o_valid=0, flushed dispatch not enqueued.
REQ-036 Continuous enqueue/issue for 3*DEPTH cycles with all ready=1 -> pointer wrap-around, every id issued exactly once in order; with bypass on, count_o stays 0 and issue is in the enqueue cycle; with bypass off, issue occurs 1 cycle later.
REQ-037 Assert rstn low with count_o=2 -> fuinput_o_valid=0 immediately; after release, count_o=0 and no old id issues.

Source files
------------

// File: rtl/fu_issue_queue.sv
// In-order issue queue between dispatch and the functional units; only the head entry is ever offered.
// Optional macro FU_ISSUE_QUEUE_BYPASS_EN: an empty queue forwards dispatch_i straight to fuinput_o.
package fu_issue_queue_pkg;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BRU = 2'd3
  } fu_t;

  localparam int unsigned NUM_FU = 4;

  typedef logic [NUM_FU-1:0] fu_bitvector_t;

  typedef struct packed {
    fu_t         fu;
    logic [7:0]  id;
    logic [15:0] op;
  } fu_input_t;

endpackage

module fu_issue_queue
  import fu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  fu_input_t              dispatch_i,
  input  logic                   dispatch_i_valid,
  output logic                   dispatch_i_ready,
  input  logic                   flush_i,
  output fu_input_t              fuinput_o,
  output logic                   fuinput_o_valid,
  input  fu_bitvector_t          fuinput_o_ready,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fu_input_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      empty;
  logic      enq;
  logic      issue;
  logic      wr_en;
  logic      deq;
  fu_input_t head;

  assign empty            = (count_q == '0);
  assign dispatch_i_ready = (count_q < FULL_CNT) && !flush_i;
  assign enq              = dispatch_i_valid && dispatch_i_ready;

`ifdef FU_ISSUE_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass = empty && !flush_i && dispatch_i_valid;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head            = mem_q[rd_ptr_q];
    fuinput_o_valid = !empty && !flush_i;
    if (bypass) begin
      head            = dispatch_i;
      fuinput_o_valid = 1'b1;
    end
  end

  // A bypassed instruction the FU takes never touches storage; one it refuses is queued as usual.
  assign wr_en = enq && !(bypass && issue);
  assign deq   = issue && !bypass;
`else
  assign head            = mem_q[rd_ptr_q];
  assign fuinput_o_valid = !empty && !flush_i;
  assign wr_en           = enq;
  assign deq             = issue;
`endif

  // Idle outputs are forced to zero so stale storage never leaks to the FUs.
  assign fuinput_o = fuinput_o_valid ? head : '0;
  assign issue     = fuinput_o_valid && fuinput_o_ready[fuinput_o.fu];
  assign count_o   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({wr_en, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left without reset; count_q gates every read, so its contents never matter while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= dispatch_i;
    end
  end

endmodule

// File: tb/tb_fu_issue_queue.sv
// Directed self-checking bench for fu_issue_queue (DEPTH = 4); expectations follow the bypass macro setting.
module tb_fu_issue_queue;
  import fu_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  fu_input_t     dispatch_i;
  logic          dispatch_i_valid;
  logic          dispatch_i_ready;
  logic          flush_i;
  fu_input_t     fuinput_o;
  logic          fuinput_o_valid;
  fu_bitvector_t fuinput_o_ready;
  logic [$clog2(DEPTH):0] count_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .dispatch_i       (dispatch_i),
    .dispatch_i_valid (dispatch_i_valid),
    .dispatch_i_ready (dispatch_i_ready),
    .flush_i          (flush_i),
    .fuinput_o        (fuinput_o),
    .fuinput_o_valid  (fuinput_o_valid),
    .fuinput_o_ready  (fuinput_o_ready),
    .count_o          (count_o)
  );

  // Inputs change 1 time unit after a rising edge; checks happen 1 unit later, mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fu_t f, input int id);
    dispatch_i.fu    = f;
    dispatch_i.id    = 8'(id);
    dispatch_i.op    = 16'(id * 3);
    dispatch_i_valid = 1'b1;
  endtask

  task automatic idle();
    dispatch_i       = '0;
    dispatch_i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    flush_i         = 1'b0;
    fuinput_o_ready = '0;
    idle();
    #1;
    n_checks++; if (count_o !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count_o); else n_pass++;
    n_checks++; if (fuinput_o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", fuinput_o_valid); else n_pass++;
    n_checks++; if (fuinput_o !== fu_input_t'('0)) $display("FAIL reset_data: got %h expected 0", fuinput_o); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    n_checks++; if (dispatch_i_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", dispatch_i_ready); else n_pass++;
  endtask

  task automatic test_fill_block();
    fuinput_o_ready = '0;
    for (int i = 1; i <= 4; i++) begin
      drive(FU_ALU, i);
      #1;
      n_checks++; if (dispatch_i_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b expected 1", i, dispatch_i_ready); else n_pass++;
      step();
    end
    drive(FU_MUL, 99);
    #1;
    n_checks++; if (count_o !== 3'd4) $display("FAIL full_count: got %0d expected 4", count_o); else n_pass++;
    n_checks++; if (dispatch_i_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", dispatch_i_ready); else n_pass++;
    n_checks++; if (fuinput_o_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", fuinput_o_valid); else n_pass++;
    n_checks++; if (fuinput_o.op !== 16'd3) $display("FAIL full_head_op: got %0d expected 3", fuinput_o.op); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      step();
      #1;
      n_checks++; if (fuinput_o.id !== 8'd1 || fuinput_o_valid !== 1'b1)
        $display("FAIL hold_head_c%0d: got id %0d valid %b expected id 1 valid 1", c, fuinput_o.id, fuinput_o_valid);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_in_order_issue();
    fuinput_o_ready         = '0;
    fuinput_o_ready[FU_ALU] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (fuinput_o.id !== 8'(k + 1) || fuinput_o_valid !== 1'b1)
        $display("FAIL issue_order_%0d: got id %0d valid %b expected id %0d valid 1", k, fuinput_o.id, fuinput_o_valid, k + 1);
      else n_pass++;
      if (k == 0) begin
        n_checks++; if (dispatch_i_ready !== 1'b0) $display("FAIL issue_ready_full: got %b expected 0", dispatch_i_ready); else n_pass++;
      end
      if (k == 1) begin
        n_checks++; if (dispatch_i_ready !== 1'b1) $display("FAIL issue_ready_back: got %b expected 1", dispatch_i_ready); else n_pass++;
      end
      step();
    end
    #1;
    n_checks++; if (count_o !== 3'd0) $display("FAIL drained_count: got %0d expected 0", count_o); else n_pass++;
    n_checks++; if (fuinput_o !== fu_input_t'('0) || fuinput_o_valid !== 1'b0)
      $display("FAIL drained_out: got %h valid %b expected 0 valid 0", fuinput_o, fuinput_o_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_fu_blocking();
    fuinput_o_ready = '0;
    drive(FU_LSU, 5);
    step();
    drive(FU_ALU, 6);
    step();
    idle();
    fuinput_o_ready[FU_ALU] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (count_o !== 3'd2) $display("FAIL block_count_c%0d: got %0d expected 2", c, count_o); else n_pass++;
      n_checks++; if (fuinput_o.id !== 8'd5) $display("FAIL block_head_c%0d: got %0d expected 5", c, fuinput_o.id); else n_pass++;
      step();
    end
    fuinput_o_ready = '1;
    #1;
    n_checks++; if (fuinput_o.id !== 8'd5) $display("FAIL unblock_first: got %0d expected 5", fuinput_o.id); else n_pass++;
    step();
    #1;
    n_checks++; if (fuinput_o.id !== 8'd6) $display("FAIL unblock_second: got %0d expected 6", fuinput_o.id); else n_pass++;
    step();
    #1;
    n_checks++; if (count_o !== 3'd0) $display("FAIL unblock_count: got %0d expected 0", count_o); else n_pass++;
    step();
  endtask

  task automatic test_flush();
    fuinput_o_ready = '0;
    for (int i = 7; i <= 9; i++) begin
      drive(FU_MUL, i);
      step();
    end
    drive(FU_ALU, 10);
    flush_i = 1'b1;
    #1;
    n_checks++; if (count_o !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", count_o); else n_pass++;
    n_checks++; if (fuinput_o_valid !== 1'b0) $display("FAIL flush_cycle_valid: got %b expected 0", fuinput_o_valid); else n_pass++;
    n_checks++; if (dispatch_i_ready !== 1'b0) $display("FAIL flush_cycle_ready: got %b expected 0", dispatch_i_ready); else n_pass++;
    step();
    flush_i = 1'b0;
    idle();
    #1;
    n_checks++; if (count_o !== 3'd0) $display("FAIL flush_count: got %0d expected 0", count_o); else n_pass++;
    n_checks++; if (fuinput_o_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", fuinput_o_valid); else n_pass++;
    step();
    drive(FU_BRU, 11);
    step();
    idle();
    fuinput_o_ready = '1;
    #1;
    n_checks++; if (fuinput_o.id !== 8'd11 || fuinput_o.fu !== FU_BRU)
      $display("FAIL post_flush_head: got id %0d fu %0d expected id 11 fu 3", fuinput_o.id, fuinput_o.fu);
    else n_pass++;
    step();
    #1;
    n_checks++; if (count_o !== 3'd0) $display("FAIL post_flush_count: got %0d expected 0", count_o); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    fuinput_o_ready = '1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      drive(fu_t'(k[1:0]), 20 + k);
      #1;
`ifdef FU_ISSUE_QUEUE_BYPASS_EN
      n_checks++; if (fuinput_o_valid !== 1'b1 || fuinput_o.id !== 8'(20 + k) || count_o !== 3'd0)
        $display("FAIL b2b_%0d: got valid %b id %0d count %0d expected valid 1 id %0d count 0",
                 k, fuinput_o_valid, fuinput_o.id, count_o, 20 + k);
      else n_pass++;
`else
      if (k == 0) begin
        n_checks++; if (fuinput_o_valid !== 1'b0 || count_o !== 3'd0)
          $display("FAIL b2b_first: got valid %b count %0d expected valid 0 count 0", fuinput_o_valid, count_o);
        else n_pass++;
      end else begin
        n_checks++; if (fuinput_o_valid !== 1'b1 || fuinput_o.id !== 8'(19 + k) || count_o !== 3'd1)
          $display("FAIL b2b_%0d: got valid %b id %0d count %0d expected valid 1 id %0d count 1",
                   k, fuinput_o_valid, fuinput_o.id, count_o, 19 + k);
        else n_pass++;
      end
`endif
      step();
    end
    idle();
    #1;
`ifdef FU_ISSUE_QUEUE_BYPASS_EN
    n_checks++; if (fuinput_o_valid !== 1'b0) $display("FAIL b2b_tail: got valid %b expected 0", fuinput_o_valid); else n_pass++;
`else
    n_checks++; if (fuinput_o_valid !== 1'b1 || fuinput_o.id !== 8'd31)
      $display("FAIL b2b_tail: got valid %b id %0d expected valid 1 id 31", fuinput_o_valid, fuinput_o.id);
    else n_pass++;
`endif
    step();
    #1;
    n_checks++; if (count_o !== 3'd0 || fuinput_o_valid !== 1'b0)
      $display("FAIL b2b_empty: got count %0d valid %b expected 0 0", count_o, fuinput_o_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    fuinput_o_ready = '0;
    drive(FU_ALU, 40);
    step();
    drive(FU_LSU, 41);
    step();
    idle();
    #1;
    n_checks++; if (count_o !== 3'd2) $display("FAIL mid_pre_count: got %0d expected 2", count_o); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (fuinput_o_valid !== 1'b0 || fuinput_o !== fu_input_t'('0))
      $display("FAIL mid_async_out: got valid %b data %h expected 0 0", fuinput_o_valid, fuinput_o);
    else n_pass++;
    n_checks++; if (count_o !== 3'd0) $display("FAIL mid_async_count: got %0d expected 0", count_o); else n_pass++;
    step();
    step();
    rstn            = 1'b1;
    fuinput_o_ready = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      n_checks++; if (fuinput_o_valid !== 1'b0 || count_o !== 3'd0)
        $display("FAIL mid_post_c%0d: got valid %b id %0d count %0d expected valid 0 count 0",
                 c, fuinput_o_valid, fuinput_o.id, count_o);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill_block();
    test_in_order_issue();
    test_fu_blocking();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
